// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational ALU between two requesters.
//                Round-robin grant in IDLE. The winner's operands and command
//                are registered onto the ALU inputs. They are held for SETTLE
//                cycles so the ripple chain can settle. The result and flags
//                are then captured and returned over a valid/ready response.
//  Ports       : clk, rst_n (sync, active-low)
//                req_valid/ready/a/b/cmd [0|1]  - request channels
//                rsp_valid/ready [0|1]          - response handshake
//                rsp_result, rsp_carryout/zero/overflow - shared response bus
//                alu_operandA/B, alu_command    - registered drive to the ALU
//                alu_result, alu_carryout/zero/overflow - from the ALU
//                busy                           - high outside IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_cmd0,
  input  logic [2:0]       req_cmd1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy
);

  // A SETTLE of 0 is treated as 1 so that capture never happens on the
  // same edge that loads the ALU inputs.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;       // requester served most recently
  logic             id_q, id_d;           // requester owning the in-flight op
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic grant0, grant1;
  logic sel_rsp_ready;

  always_comb begin
    // On a tie the requester that was not served last wins.
    grant0 = req_valid0 && (!req_valid1 || last_q);
    grant1 = req_valid1 && (!req_valid0 || !last_q);
    // rst_n gates ready so nothing is accepted while reset is asserted.
    req_ready0 = (state_q == ST_IDLE) && grant0 && rst_n;
    req_ready1 = (state_q == ST_IDLE) && grant1 && rst_n;
    // Only the owner's rsp_ready can complete the response.
    sel_rsp_ready = id_q ? rsp_ready1 : rsp_ready0;

    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cmd_d       = cmd_q;
    res_d       = res_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (req_ready0) begin
          op_a_d  = req_a0;
          op_b_d  = req_b0;
          cmd_d   = req_cmd0;
          id_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end else if (req_ready1) begin
          op_a_d  = req_a1;
          op_b_d  = req_b1;
          cmd_d   = req_cmd1;
          id_d    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d       = alu_result;
          cout_d      = alu_carryout;
          zero_d      = alu_zero;
          ovf_d       = alu_overflow;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_valid_q && sel_rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = id_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cmd_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cmd_q       <= cmd_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid0   = rsp_valid_q && !id_q;
  assign rsp_valid1   = rsp_valid_q && id_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = cout_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign alu_operandA = op_a_q;
  assign alu_operandB = op_b_q;
  assign alu_command  = cmd_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. Drivers issue directed
//                requests, the expected responses are queued in grant order,
//                and a monitor compares every response handshake against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] XOR_ = 3'b010;
  localparam logic [2:0] SLT  = 3'b011;
  localparam logic [2:0] AND_ = 3'b100;
  localparam logic [2:0] NAND = 3'b101;
  localparam logic [2:0] NOR_ = 3'b110;
  localparam logic [2:0] OR_  = 3'b111;

  logic        clk, rst_n;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]  req_cmd0, req_cmd1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_zero, rsp_overflow;
  logic [31:0] alu_operandA, alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        busy;

  alu_arbiter #(.WIDTH(32), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. SUB is a + ~b + 1, so carryout is the no-borrow flag.
  // SLT and the logic ops report carryout = overflow = 0.
  always_comb begin
    logic [32:0] sum;
    sum          = 33'd0;
    alu_result   = 32'd0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      ADD: begin
        sum          = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = sum[31:0];
        alu_carryout = sum[32];
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (sum[31] != alu_operandA[31]);
      end
      SUB: begin
        sum          = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = sum[31:0];
        alu_carryout = sum[32];
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (sum[31] != alu_operandA[31]);
      end
      XOR_: alu_result = alu_operandA ^ alu_operandB;
      SLT:  alu_result = ($signed(alu_operandA) < $signed(alu_operandB)) ? 32'd1 : 32'd0;
      AND_: alu_result = alu_operandA & alu_operandB;
      NAND: alu_result = ~(alu_operandA & alu_operandB);
      NOR_: alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    int          id;
    logic [31:0] r;
    logic        c, z, o;
  } exp_t;

  typedef struct {
    int id;
    int cyc;
  } grant_t;

  exp_t   exp_q[$];
  grant_t grant_log[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] r, input logic c, input logic z, input logic o);
    exp_t e;
    e.id = id; e.r = r; e.c = c; e.z = z; e.o = o;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every response handshake and logs every acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((rsp_valid0 && rsp_valid1) || (req_ready0 && req_ready1)) begin
        n_cmp++; n_err++;
        $display("FAIL onehot: rsp_valid=%b%b req_ready=%b%b", rsp_valid1, rsp_valid0, req_ready1, req_ready0);
      end
      if (req_valid0 && req_ready0) begin
        grant_t g; g.id = 0; g.cyc = cyc; grant_log.push_back(g);
      end
      if (req_valid1 && req_ready1) begin
        grant_t g; g.id = 1; g.cyc = cyc; grant_log.push_back(g);
      end
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? (rsp_valid0 && rsp_ready0) : (rsp_valid1 && rsp_ready1)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rsp: requester %0d result 0x%08h, none expected", i, rsp_result);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.id != i || rsp_result !== e.r || rsp_carryout !== e.c ||
                rsp_zero !== e.z || rsp_overflow !== e.o) begin
              n_err++;
              $display("FAIL rsp: got id=%0d r=0x%08h c=%b z=%b o=%b expected id=%0d r=0x%08h c=%b z=%b o=%b",
                       i, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, e.id, e.r, e.c, e.z, e.o);
            end
          end
        end
      end
    end
  end

  // Presents one request and returns #1 after the accepting edge.
  task automatic drive_req(input int id, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int  n;
    logic rdy;
    if (id == 0) begin req_valid0 = 1'b1; req_cmd0 = cmd; req_a0 = a; req_b0 = b; end
    else         begin req_valid1 = 1'b1; req_cmd1 = cmd; req_a1 = a; req_b1 = b; end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (id == 0) ? req_ready0 : req_ready1;
      n++;
    end
    if (!rdy) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: requester %0d got ready=0 expected 1", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_opA"},   alu_operandA, 32'd0);
    check({tag, "_opB"},   alu_operandB, 32'd0);
    check({tag, "_cmd"},   {29'd0, alu_command}, 32'd0);
    check({tag, "_res"},   rsp_result, 32'd0);
    check({tag, "_flags"}, {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
    check({tag, "_vld"},   {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] snap_res, snap_a;
    logic        stable;

    rst_n = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_cmd0 = '0; req_cmd1 = '0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    // ---- reset state; ready forced low while in reset ----
    repeat (2) @(posedge clk);
    #1;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    @(negedge clk);
    check("rst_ready", {30'd0, req_ready1, req_ready0}, 32'd0);
    check_all_zero("rst");
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- single op: ADD 5 + 7, latency to rsp_valid0 ----
    push_exp(0, 32'd12, 1'b0, 1'b0, 1'b0);
    drive_req(0, ADD, 32'd5, 32'd7);
    check("single_opA", alu_operandA, 32'd5);
    check("single_busy", {31'd0, busy}, 32'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid0 && n < 20);
    check("single_latency", 32'(n), 32'd4);
    check("single_rsp_valid1", {31'd0, rsp_valid1}, 32'd0);
    wait_drain();

    // ---- reset during SETTLE discards the op ----
    drive_req(0, ADD, 32'd9, 32'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid0 || rsp_valid1) stable = 1'b0;
    end
    check("midrst_no_rsp", {31'd0, stable}, 32'd1);

    // ---- tie after reset: req0 first, req1 six cycles later ----
    grant_log.delete();
    push_exp(0, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
    push_exp(1, 32'd7, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    fork
      drive_req(0, OR_, 32'h00FF00FF, 32'h0F0F0F0F);
      drive_req(1, SUB, 32'd10, 32'd3);
    join
    wait_drain();
    check("tie_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("tie_first", 32'(grant_log[0].id), 32'd0);
      check("tie_spacing", 32'(grant_log[1].cyc - grant_log[0].cyc), 32'd6);
    end

    // ---- continuous contention: strict alternation ----
    grant_log.delete();
    push_exp(0, 32'd3,         1'b0, 1'b0, 1'b0);
    push_exp(1, 32'h0000FF00,  1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h0F000F00,  1'b0, 1'b0, 1'b0);
    push_exp(1, 32'h00000000,  1'b0, 1'b1, 1'b0);
    push_exp(0, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0);
    push_exp(1, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0);
    push_exp(0, 32'd1,         1'b0, 1'b0, 1'b0);
    push_exp(1, 32'd3,         1'b0, 1'b0, 1'b0);
    fork
      begin
        drive_req(0, ADD,  32'd1,        32'd2);
        drive_req(0, AND_, 32'hFF00FF00, 32'h0FF00FF0);
        drive_req(0, NOR_, 32'd0,        32'd0);
        drive_req(0, SLT,  32'd5,        32'd7);
      end
      begin
        drive_req(1, XOR_, 32'h0000F0F0, 32'h00000FF0);
        drive_req(1, NAND, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive_req(1, SUB,  32'd0,        32'd1);
        drive_req(1, OR_,  32'd1,        32'd2);
      end
    join
    wait_drain();
    check("cont_grants", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size(); k++)
      check($sformatf("cont_grant%0d", k), 32'(grant_log[k].id), 32'(k % 2));

    // ---- backpressure on requester 0 while requester 1 waits ----
    rsp_ready0 = 1'b0;
    push_exp(0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
    push_exp(1, 32'h00000000, 1'b1, 1'b1, 1'b0);
    drive_req(0, AND_, 32'h0000FFFF, 32'h00FF00FF);
    fork
      drive_req(1, ADD, 32'hFFFFFFFF, 32'd1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rsp_valid0 && n < 20);
        check("bp_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
        snap_res = rsp_result;
        snap_a   = alu_operandA;
        stable   = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!rsp_valid0 || rsp_result !== snap_res || alu_operandA !== snap_a ||
              !busy || req_ready1 || !req_valid1) stable = 1'b0;
        end
        check("bp_hold", {31'd0, stable}, 32'd1);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        check("bp_release_idle", {30'd0, busy, req_ready1}, 32'd1);
      end
    join
    wait_drain();

    // ---- flag pass-through ----
    push_exp(0, 32'h80000000, 1'b0, 1'b0, 1'b1);
    push_exp(0, 32'h00000000, 1'b1, 1'b1, 1'b0);
    drive_req(0, ADD, 32'h7FFFFFFF, 32'h00000001);
    drive_req(0, SUB, 32'd3, 32'd3);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
